alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Parametrised sequential multiply/divide unit for the MIPS_Pro_32 datapath. It is the multi-cycle successor to ALU_32's start-driven operation and serves MULT/MULTU/DIV/DIVU.
- Inputs: two WIDTH-bit operands.
- Outputs: a double-width product, or quotient plus remainder, on result/buffer (LO/HI).
- Handshake: start/busy/done. Flags: zero, divide-by-zero.
- One shift-add or restoring-subtract iteration per clock.

Parameters:
- WIDTH, 32, operand width and result/buffer width (supported range 4..64).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A (multiplicand / dividend)
- b  input  WIDTH  operand B (multiplier / divisor)
- alu_control  input  4  operation: 0001 MULTU, 0010 MULT, 0011 DIVU, 0100 DIV
- start  input  1  request; sampled only when busy=0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result/buffer/flags updated
- result  output  WIDTH  product low half (LO) / quotient
- buffer  output  WIDTH  product high half (HI) / remainder
- zero  output  1  result==0 && buffer==0 for multiply; quotient==0 for divide
- div_zero  output  1  last completed divide had b==0

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, zero and div_zero = 0; result, buffer, iteration counter and internal registers = 0. Takes effect immediately, including mid-operation. The operation in flight is discarded with no done pulse.
- States:
  - IDLE: wait for start.
  - CALC: exactly WIDTH cycles, counter WIDTH-1 down to 0.
  - DONE: one cycle; sign fix-up, output register load, done=1.
  - Then back to IDLE.
- busy = (state != IDLE). start is ignored whenever busy=1, including the DONE cycle.
- Accept: edge with state=IDLE, start=1 and a valid code. a, b and alu_control are latched at that edge; later input changes do not affect the operation.
- Invalid code with start=1: ignored. The unit stays IDLE and outputs are unchanged.
- Latency: accepting edge at cycle k gives done=1 during cycle k+WIDTH+1. result/buffer/zero/div_zero change only at the edge entering DONE and hold until the next DONE.
- Multiply:
  - 2*WIDTH accumulator; each cycle conditional add of the multiplicand, then shift right.
  - {buffer,result} = full product, no truncation.
- Divide:
  - Restoring algorithm; each cycle shift the remainder left, trial-subtract the divisor, set a quotient bit.
  - result = quotient, buffer = remainder.
- b==0 on divide: result = all ones, buffer = latched a, div_zero=1, zero=0. The full WIDTH+1 latency still applies.
- div_zero is cleared on every DONE that is not a divide-by-zero.
- Signed ops (MULT, DIV):
  - Operand magnitudes are taken at accept; signs are applied in DONE.
  - Product sign = sign(a)^sign(b).
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a). Truncating division.
  - Overflow case MIN/-1: result = MIN (wraps), buffer = 0, no flag.
- done is asserted in DONE only. It never asserts for two consecutive cycles.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: codes 0010 (MULT) and 0100 (DIV) perform signed arithmetic as specified above.
- Undefined:
  - 0010 behaves exactly as 0001 and 0100 behaves exactly as 0011 (unsigned).
  - Sign-conversion and fix-up logic is absent.
  - Timing is identical.

Test Plan:
- MULTU: a=100000000, b=2000, start pulse -> done at k+33; buffer=0x0000002E, result=0x90EDD000, zero=0.
- DIVU: a=100000000, b=2000 -> result=0x0000C350, buffer=0x00000000, zero=0, div_zero=0.
- Signed (MULDIV_SIGNED_EN defined):
  - MULT a=-3, b=5 -> buffer=0xFFFFFFFF, result=0xFFFFFFF1.
  - DIV a=-7, b=2 -> result=0xFFFFFFFD, buffer=0xFFFFFFFF.
  - Macro undefined, MULT a=-3, b=5 -> unsigned product buffer=0x00000004, result=0xFFFFFFF1.
- Divide by zero: DIVU a=1234, b=0 -> result=0xFFFFFFFF, buffer=0x000004D2, div_zero=1. A following MULTU 0x0 by 0x0 -> zero=1, div_zero=0.
- Start while busy, then reset: second start 5 cycles after the first -> ignored; exactly one done pulse, first operation's results. Next operation: reset_n=0 at cycle 10 of CALC -> busy=0 and outputs=0 immediately, no done; a new start after release completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequential multiply/divide unit: one shift-add or restoring-subtract step per clock.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they run unsigned.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] buffer,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_n;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] a_lat;
  logic             op_div;
  logic             op_dz;

  logic             code_ok;
  logic             code_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign code_ok  = (alu_control == 4'b0001) || (alu_control == 4'b0010) ||
                    (alu_control == 4'b0011) || (alu_control == 4'b0100);
  assign code_div = (alu_control == 4'b0011) || (alu_control == 4'b0100);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef MULDIV_SIGNED_EN
  logic op_sgn;
  logic neg_q;
  logic neg_r;

  assign op_sgn = (alu_control == 4'b0010) || (alu_control == 4'b0100);
  assign a_mag  = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (op_sgn && b[WIDTH-1]) ? -b : b;

  // Signs captured at accept; magnitudes run through the core.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == S_IDLE && start && code_ok) begin
      neg_q <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= op_sgn & a[WIDTH-1];
    end
  end

  always_comb begin
    prod  = neg_q ? -acc_n : acc_n;
    q_fix = neg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    r_fix = neg_r ? -acc_n[W2-1:WIDTH] : acc_n[W2-1:WIDTH];
  end
`else
  assign a_mag = a;
  assign b_mag = b;

  always_comb begin
    prod  = acc_n;
    q_fix = acc_n[WIDTH-1:0];
    r_fix = acc_n[W2-1:WIDTH];
  end
`endif

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  // Multiply: acc = {hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_s = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
    shl   = acc[W2-1:WIDTH-1];
    diff  = shl[WIDTH-1:0] - opb;
    acc_n = {add_s, acc[WIDTH-1:1]};
    if (op_div) begin
      if (shl >= {1'b0, opb})
        acc_n = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_n = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] buf_n;
  logic             zero_n;

  always_comb begin
    res_n  = prod[WIDTH-1:0];
    buf_n  = prod[W2-1:WIDTH];
    zero_n = (prod == '0);
    if (op_dz) begin
      res_n  = '1;
      buf_n  = a_lat;
      zero_n = 1'b0;
    end else if (op_div) begin
      res_n  = q_fix;
      buf_n  = r_fix;
      zero_n = (q_fix == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_lat    <= '0;
      op_div   <= 1'b0;
      op_dz    <= 1'b0;
      result   <= '0;
      buffer   <= '0;
      zero     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && code_ok) begin
            state  <= S_CALC;
            cnt    <= CW'(WIDTH - 1);
            op_div <= code_div;
            op_dz  <= code_div && (b == '0);
            a_lat  <= a;
            if (code_div) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opb <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opb <= a_mag;
            end
          end
        end
        S_CALC: begin
          acc <= acc_n;
          if (cnt == '0) begin
            state    <= S_DONE;
            result   <= res_n;
            buffer   <= buf_n;
            zero     <= zero_n;
            div_zero <= op_dz;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed cases plus random ops
// against a plain-arithmetic model.
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clock;
  logic          reset_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    alu_control;
  logic          start;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  buffer;
  logic          zero;
  logic          div_zero;

  int total = 0;
  int bad   = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .buffer      (buffer),
    .zero        (zero),
    .div_zero    (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {div_zero, zero, hi, lo}.
  function automatic logic [65:0] model(input logic [31:0] ma,
                                        input logic [31:0] mb,
                                        input logic [3:0]  mc);
    logic        sg;
    logic        isdiv;
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    int          ia;
    int          ib;
    longint      la;
    longint      lb;
    sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sg = (mc == 4'd2) || (mc == 4'd4);
`endif
    isdiv = (mc == 4'd3) || (mc == 4'd4);
    ia = ma;
    ib = mb;
    if (!isdiv) begin
      if (sg) begin
        la = ia;
        lb = ib;
        p = la * lb;
      end else begin
        p = {32'd0, ma} * {32'd0, mb};
      end
      return {1'b0, p == 64'd0, p};
    end
    if (mb == 32'd0)
      return {1'b1, 1'b0, ma, 32'hFFFF_FFFF};
    if (sg) begin
      if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        q = ma;
        r = 32'd0;
      end else begin
        q = ia / ib;
        r = ia % ib;
      end
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    return {1'b0, q == 32'd0, r, q};
  endfunction

  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       input logic [3:0] oc, input string tag);
    logic [65:0] m;
    int          n;
    m = model(oa, ob, oc);
    @(negedge clock);
    a = oa;
    b = ob;
    alu_control = oc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    alu_control = 4'($urandom_range(1, 4));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(W + 1));
    chk({tag, " result"}, 64'(result), 64'(m[31:0]));
    chk({tag, " buffer"}, 64'(buffer), 64'(m[63:32]));
    chk({tag, " zero"}, 64'(zero), 64'(m[64]));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(m[65]));
    @(negedge clock);
    chk({tag, " done_once"}, 64'(done), 64'd0);
    chk({tag, " hold"}, {buffer, result}, m[63:0]);
  endtask

  initial begin
    logic [31:0] sr;
    logic [31:0] sb;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rc;
    logic [65:0] m;
    int          dones;

    reset_n = 1'b0;
    a = '0;
    b = '0;
    alu_control = '0;
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst out", {buffer, result}, 64'd0);
    chk("rst flags", {62'd0, zero, div_zero}, 64'd0);
    reset_n = 1'b1;

    do_op(32'd100000000, 32'd2000, 4'd1, "multu");
    chk("tp multu", {buffer, result}, 64'h0000002E_90EDD000);
    do_op(32'd100000000, 32'd2000, 4'd3, "divu");
    chk("tp divu", {buffer, result}, 64'h00000000_0000C350);
    do_op(-32'sd3, 32'd5, 4'd2, "mult");
`ifdef MULDIV_SIGNED_EN
    chk("tp mult", {buffer, result}, 64'hFFFFFFFF_FFFFFFF1);
`else
    chk("tp mult", {buffer, result}, 64'h00000004_FFFFFFF1);
`endif
    do_op(-32'sd7, 32'd2, 4'd4, "div");
`ifdef MULDIV_SIGNED_EN
    chk("tp div", {buffer, result}, 64'hFFFFFFFF_FFFFFFFD);
`else
    chk("tp div", {buffer, result}, 64'h00000001_7FFFFFFC);
`endif
    do_op(32'd1234, 32'd0, 4'd3, "divu0");
    chk("tp divu0", {buffer, result}, 64'h000004D2_FFFFFFFF);
    do_op(32'd0, 32'd0, 4'd1, "mul00");
    chk("tp mul00 flags", {62'd0, zero, div_zero}, 64'd2);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd4, "minm1");
    do_op(32'h8000_0000, 32'd0, 4'd4, "sdiv0");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, "multu_max");
    do_op(32'd5, 32'd9, 4'd3, "divu_small");

    // Invalid codes are ignored and leave outputs alone.
    do_op(32'd77, 32'd3, 4'd1, "pre_inv");
    sr = result;
    sb = buffer;
    @(negedge clock);
    a = 32'd1;
    b = 32'd1;
    alu_control = 4'd0;
    start = 1'b1;
    @(negedge clock);
    alu_control = 4'b1111;
    @(negedge clock);
    start = 1'b0;
    chk("inv busy", 64'(busy), 64'd0);
    chk("inv out", {buffer, result}, {sb, sr});
    @(negedge clock);
    chk("inv done", 64'(done), 64'd0);

    // Second start while busy is dropped.
    m = model(32'h1234_5678, 32'h0000_9ABC, 4'd1);
    @(negedge clock);
    a = 32'h1234_5678;
    b = 32'h0000_9ABC;
    alu_control = 4'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    sr = '0;
    sb = '0;
    for (int i = 1; i <= W + 8; i++) begin
      if (i == 5) begin
        a = 32'd99;
        b = 32'd7;
        alu_control = 4'd3;
        start = 1'b1;
      end
      if (i == 6) start = 1'b0;
      if (done) begin
        dones++;
        sr = result;
        sb = buffer;
      end
      @(negedge clock);
    end
    chk("busy_start dones", 64'(dones), 64'd1);
    chk("busy_start out", {sb, sr}, m[63:0]);
    chk("busy_start idle", 64'(busy), 64'd0);

    // Reset in the middle of CALC.
    @(negedge clock);
    a = 32'd1000;
    b = 32'd3;
    alu_control = 4'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst busy", 64'(busy), 64'd0);
    chk("mid_rst done", 64'(done), 64'd0);
    chk("mid_rst out", {buffer, result}, 64'd0);
    chk("mid_rst flags", {62'd0, zero, div_zero}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("mid_rst no_done", 64'(dones), 64'd0);
    do_op(32'd1000, 32'd3, 4'd3, "post_rst");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 4'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      do_op(ra, rb, rc, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
